// File: rtl/arithmetic_pkg.sv
// Shared arithmetic definitions: IEEE-754 double constants, arbiter FSM
// encodings, exponentiator status flag positions and an index-wrap helper.
package arithmetic_pkg;

    localparam int DOUBLE_SIZE = 64;

    // All-zero double bit pattern (+0.0), used as the reset value of results.
    localparam logic [DOUBLE_SIZE-1:0] ZERO_DATA = '0;

    // Arbiter FSM encoding; the fourth code is unused and decodes back to idle.
    typedef enum logic [1:0] {
        IDLE_STATE  = 2'b00,
        ISSUE_STATE = 2'b01,
        WAIT_STATE  = 2'b10
    } arbiter_state_t;

    // Bit positions inside the exponentiator status word.
    localparam int STATUS_OVERFLOW  = 0;
    localparam int STATUS_UNDERFLOW = 1;
    localparam int STATUS_INVALID   = 2;
    localparam int STATUS_INEXACT   = 3;
    localparam int STATUS_FLAGS     = 4;

    // Wraps an index that is at most one modulus past the end back into range.
    function automatic int wrap_index(input int value, input int modulus);
        if (value >= modulus) begin
            return value - modulus;
        end
        return value;
    endfunction

endpackage

// File: rtl/model_scalar_exponentiator_function.sv
// Two-stage scalar exponentiator model: computes exp() of an IEEE-754 double.
// START captures the operand; READY pulses two cycles later with the result
// and a status word (overflow, underflow, invalid, inexact).
module model_scalar_exponentiator_function
    import arithmetic_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic [DATA_SIZE-1:0]    DATA_IN,
    output logic                    READY,
    output logic [DATA_SIZE-1:0]    DATA_OUT,
    output logic [CONTROL_SIZE-1:0] STATUS
);

    logic                    stage_valid;
    logic [DOUBLE_SIZE-1:0]  operand_reg;
    real                     operand_real;
    real                     result_real;
    logic [DOUBLE_SIZE-1:0]  result_bits;
    logic                    operand_finite;
    logic                    operand_nan;
    logic                    result_inf;
    logic                    result_tiny;
    logic [STATUS_FLAGS-1:0] flags;
    logic                    ready_reg;
    logic [DATA_SIZE-1:0]    data_out_reg;
    logic [CONTROL_SIZE-1:0] status_reg;

    // Stage 1: capture the operand and mark the stage occupied.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            stage_valid <= 1'b0;
            operand_reg <= ZERO_DATA;
        end else begin
            stage_valid <= START;
            if (START) begin
                operand_reg <= DOUBLE_SIZE'(DATA_IN);
            end
        end
    end

    // Evaluate exp() on the captured double and classify the outcome.
    always_comb begin
        operand_real   = $bitstoreal(operand_reg);
        result_real    = $exp(operand_real);
        result_bits    = $realtobits(result_real);
        operand_finite = (operand_reg[62:52] != 11'h7FF);
        operand_nan    = !operand_finite && (operand_reg[51:0] != 52'h0);
        result_inf     = (result_bits[62:52] == 11'h7FF) && (result_bits[51:0] == 52'h0);
        result_tiny    = (result_bits[62:52] == 11'h000);
        flags                   = '0;
        flags[STATUS_OVERFLOW]  = operand_finite && result_inf;
        flags[STATUS_UNDERFLOW] = operand_finite && result_tiny;
        flags[STATUS_INVALID]   = operand_nan;
        flags[STATUS_INEXACT]   = !operand_nan && (operand_reg[62:0] != 63'h0);
    end

    // Stage 2: register the result and raise READY for one cycle.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ready_reg    <= 1'b0;
            data_out_reg <= DATA_SIZE'(ZERO_DATA);
            status_reg   <= '0;
        end else begin
            ready_reg <= stage_valid;
            if (stage_valid) begin
                data_out_reg <= DATA_SIZE'(result_bits);
                status_reg   <= CONTROL_SIZE'(flags);
            end
        end
    end

    assign READY    = ready_reg;
    assign DATA_OUT = data_out_reg;
    assign STATUS   = status_reg;

endmodule

// File: rtl/model_scalar_exponentiator_arbiter.sv
// Round-robin arbiter sharing one scalar exponentiator between REQUESTERS
// clients. Requests are remembered as pending bits, served one at a time in
// rotating order, and each result is returned with a one-cycle READY pulse.
module model_scalar_exponentiator_arbiter
    import arithmetic_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4,
    parameter int REQUESTERS   = 4
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [REQUESTERS-1:0]           START,
    input  logic [REQUESTERS*DATA_SIZE-1:0] DATA_IN,
    output logic [REQUESTERS-1:0]           READY,
    output logic [DATA_SIZE-1:0]            DATA_OUT,
    output logic                            OVERFLOW_OUT,
    output logic [$clog2(REQUESTERS)-1:0]   GRANT_OUT,
    output logic                            BUSY
);

    localparam int GRANT_SIZE = $clog2(REQUESTERS);
    localparam logic [CONTROL_SIZE-1:0] OVERFLOW_MASK = CONTROL_SIZE'(1) << STATUS_OVERFLOW;

    arbiter_state_t          state_reg;
    arbiter_state_t          state_next;
    logic [REQUESTERS-1:0]   pending_reg;
    logic [REQUESTERS-1:0]   pending_next;
    logic [REQUESTERS-1:0]   clear_mask;
    logic [GRANT_SIZE-1:0]   pointer_reg;
    logic [GRANT_SIZE-1:0]   grant_reg;
    logic [GRANT_SIZE-1:0]   candidate_index;
    logic [GRANT_SIZE-1:0]   search_index;
    logic                    search_found;
    logic [DATA_SIZE-1:0]    granted_operand;
    logic [DATA_SIZE-1:0]    operand_reg;
    logic [DATA_SIZE-1:0]    data_out_reg;
    logic [REQUESTERS-1:0]   ready_reg;
    logic                    overflow_reg;
    logic                    take_grant;
    logic                    complete;
    logic                    exp_start;
    logic                    exp_ready;
    logic [DATA_SIZE-1:0]    exp_data;
    logic [CONTROL_SIZE-1:0] exp_status;

    // Find the first pending requester at or above the pointer, wrapping around.
    always_comb begin
        search_found    = 1'b0;
        search_index    = '0;
        candidate_index = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            candidate_index = GRANT_SIZE'(wrap_index(int'(pointer_reg) + k, REQUESTERS));
            if (!search_found && pending_reg[candidate_index]) begin
                search_found = 1'b1;
                search_index = candidate_index;
            end
        end
        granted_operand = DATA_IN[int'(search_index)*DATA_SIZE +: DATA_SIZE];
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg <= IDLE_STATE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode: grant in idle, one-cycle issue, then wait for the result.
    always_comb begin
        state_next = state_reg;
        take_grant = 1'b0;
        complete   = 1'b0;
        exp_start  = 1'b0;
        case (state_reg)
            IDLE_STATE: begin
                if (search_found) begin
                    take_grant = 1'b1;
                    state_next = ISSUE_STATE;
                end
            end
            ISSUE_STATE: begin
                exp_start  = 1'b1;
                state_next = WAIT_STATE;
            end
            WAIT_STATE: begin
                if (exp_ready) begin
                    complete   = 1'b1;
                    state_next = IDLE_STATE;
                end
            end
            default: begin
                state_next = IDLE_STATE;
            end
        endcase
    end

    // Pending update: the granted bit clears, but a new START on it re-sets it.
    always_comb begin
        clear_mask = '0;
        if (take_grant) begin
            clear_mask = REQUESTERS'(1) << search_index;
        end
        pending_next = (pending_reg & ~clear_mask) | START;
    end

    // Datapath: pending bits, grant bookkeeping, operand latch and result registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            pending_reg  <= '0;
            pointer_reg  <= '0;
            grant_reg    <= '0;
            operand_reg  <= DATA_SIZE'(ZERO_DATA);
            ready_reg    <= '0;
            data_out_reg <= DATA_SIZE'(ZERO_DATA);
            overflow_reg <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            ready_reg   <= '0;
            if (take_grant) begin
                grant_reg   <= search_index;
                operand_reg <= granted_operand;
            end
            if (complete) begin
                data_out_reg <= exp_data;
                overflow_reg <= |(exp_status & OVERFLOW_MASK);
                ready_reg    <= REQUESTERS'(1) << grant_reg;
                pointer_reg  <= GRANT_SIZE'(wrap_index(int'(grant_reg) + 1, REQUESTERS));
            end
        end
    end

    model_scalar_exponentiator_function #(
        .DATA_SIZE    (DATA_SIZE),
        .CONTROL_SIZE (CONTROL_SIZE)
    ) exponentiator (
        .CLK      (CLK),
        .RST      (RST),
        .START    (exp_start),
        .DATA_IN  (operand_reg),
        .READY    (exp_ready),
        .DATA_OUT (exp_data),
        .STATUS   (exp_status)
    );

    assign READY        = ready_reg;
    assign DATA_OUT     = data_out_reg;
    assign OVERFLOW_OUT = overflow_reg;
    assign GRANT_OUT    = grant_reg;
    assign BUSY         = (state_reg != IDLE_STATE);

endmodule

// File: doc/model_scalar_exponentiator_arbiter.md
MODEL_SCALAR_EXPONENTIATOR_ARBITER -- requirements
Module: model_scalar_exponentiator_arbiter

Interface
REQ-001 Parameter DATA_SIZE, default 64: operand/result width, IEEE-754 double bit pattern.
REQ-002 Parameter CONTROL_SIZE, default 4: passed unchanged to the shared exponentiator.
REQ-003 Parameter REQUESTERS, default 4: number of requester ports, range 2..16.
REQ-004 CLK  input  1  single clock; all logic on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-low.
REQ-006 START  input  REQUESTERS  per-requester request pulse; bit i belongs to requester i.
REQ-007 DATA_IN  input  REQUESTERS*DATA_SIZE  operands, flattened; requester i at bits [i*DATA_SIZE +: DATA_SIZE].
REQ-008 READY  output  REQUESTERS  one-cycle completion pulse; bit i means DATA_OUT holds requester i's result.
REQ-009 DATA_OUT  output  DATA_SIZE  shared registered result, exp(operand) bit pattern.
REQ-010 OVERFLOW_OUT  output  1  registered overflow flag of the completed operation.
REQ-011 GRANT_OUT  output  clog2(REQUESTERS)  index of the requester currently granted or last completed.
REQ-012 BUSY  output  1  high in every state except IDLE_STATE.

Function
REQ-013 A START bit high in a cycle sets that requester's pending bit at the next edge; operand is sampled at grant, not at request.
REQ-014 START on an already-pending requester is coalesced; no second operation is generated.
REQ-015 START on the granted requester in the cycle its pending bit clears re-sets the bit (set wins over clear).
REQ-016 FSM states: IDLE_STATE, ISSUE_STATE, WAIT_STATE; encoding 2 bits; unused code returns to IDLE_STATE.
REQ-017 IDLE_STATE: no pending bit -> stay; else grant first pending index searching upward from round-robin pointer with wrap-around, latch its DATA_IN slice, clear its pending bit, update GRANT_OUT, go ISSUE_STATE.
REQ-018 ISSUE_STATE: drive exponentiator START high for exactly this one cycle with latched operand; go WAIT_STATE.
REQ-019 WAIT_STATE: on exponentiator READY, register DATA_OUT and OVERFLOW_OUT from it, pulse READY[grant] for one cycle, set pointer to grant+1 modulo REQUESTERS, go IDLE_STATE; else stay.
REQ-020 Uncontended latency: START high in cycle t -> READY[i] high in cycle t+5 exactly.
REQ-021 Sustained throughput with all requesters pending: one completion every 4 cycles, strict rotation 0,1,...,REQUESTERS-1,0.
REQ-022 At most one READY bit high in any cycle; READY all-zero in all other cycles.
REQ-023 DATA_OUT, OVERFLOW_OUT, GRANT_OUT hold their value between completions.
REQ-024 START bits arriving during an operation are queued as pending and never drop, never alter the in-flight operand.

Reset
REQ-025 RST low at an edge: state IDLE_STATE, pending bits 0, pointer 0, latched operand 0, READY 0, DATA_OUT ZERO_DATA, OVERFLOW_OUT 0, GRANT_OUT 0, BUSY 0.
REQ-026 Reset mid-operation abandons the in-flight operation: no READY pulse for it, pending requests discarded; exponentiator reset by same RST.
REQ-027 START during reset cycles is ignored.

Structure
REQ-028 ZERO_DATA and the state encodings come from arithmetic_pkg; no local redefinition of ZERO_DATA.
REQ-029 Exactly one instance of model_scalar_exponentiator_function (DATA_SIZE, CONTROL_SIZE forwarded) sharing CLK and RST; no other sub-module.
REQ-030 Round-robin search is a combinational loop over REQUESTERS; all outputs registered except BUSY (decoded from state).

Verification
REQ-031 Single request: START[2]=1 one cycle, operand 0x3FF0000000000000 (1.0) -> READY=0b0100 five cycles later, DATA_OUT=0x4005BF0A8B145769 (e), GRANT_OUT=2, OVERFLOW_OUT=0.
REQ-032 Simultaneous: START=0b1111 one cycle, operands 0.0,1.0,2.0,-1.0 -> READY order bits 0,1,2,3 at 4-cycle spacing, DATA_OUT 0x3FF0000000000000, e, e^2, e^-1.
REQ-033 Fairness: after completing requester 1, START=0b0011 together -> requester 0 wait skipped? no: pointer=2, wraps, grants 0 then 1.
REQ-034 Coalescing: START[3] high 3 consecutive cycles while BUSY -> exactly one READY[3] pulse.
REQ-035 Reset mid-operation: RST low in WAIT_STATE one cycle -> no READY pulse, BUSY=0, DATA_OUT=0, subsequent START[0] completes in 5 cycles.
REQ-036 Set-wins: START[1] asserted in requester 1's grant cycle -> two READY[1] pulses total.
